// File: rtl/lstm_pkg.sv
// Shared types and fixed-point defaults for the LSTM datapath stages.
package lstm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } mac_state_t;

    localparam int LSTM_INPUT_BITS = 16;
    localparam int LSTM_FRAC_BITS  = 8;

    localparam logic signed [LSTM_INPUT_BITS-1:0] LSTM_SAT_MAX = 16'sh7FFF;
    localparam logic signed [LSTM_INPUT_BITS-1:0] LSTM_SAT_MIN = 16'sh8000;

endpackage

// File: rtl/fxp_round_sat.sv
// Wide signed accumulator to narrow Q-format: round half-up, arithmetic shift, saturate.
module fxp_round_sat
    import lstm_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int OUT_W = LSTM_INPUT_BITS,
    parameter int FRAC  = LSTM_FRAC_BITS
) (
    input  logic [ACC_W-1:0] acc_in,
    output logic [OUT_W-1:0] res_out
);

    // Half an LSTB of the output; built as (1<<FRAC)>>1 so FRAC=0 yields zero.
    localparam logic [ACC_W:0]          ONE_F = (ACC_W+1)'(1) << FRAC;
    localparam logic signed [ACC_W-1:0] HALF  = ONE_F[ACC_W:1];
    localparam logic signed [ACC_W-1:0] MAX_A = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_A = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0] rounded;
    logic signed [ACC_W-1:0] shifted;

    always_comb begin
        rounded = $signed(acc_in) + HALF;
        shifted = rounded >>> FRAC;
        if (shifted > MAX_A) begin
            res_out = MAX_A[OUT_W-1:0];
        end else if (shifted < MIN_A) begin
            res_out = MIN_A[OUT_W-1:0];
        end else begin
            res_out = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/lstm_gate_mac.sv
// Sequential MAC for one LSTM gate pre-activation: bias + sum(weight*data), Q-format,
// two-stage (product register, accumulate) with valid/ready in and out.
module lstm_gate_mac
    import lstm_pkg::*;
#(
    parameter int INPUT_BITS_NUM = LSTM_INPUT_BITS,
    parameter int FRAC_BITS      = LSTM_FRAC_BITS,
    parameter int ACC_BITS_NUM   = 40,
    parameter int VEC_LEN        = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [INPUT_BITS_NUM-1:0] bias_in,
    input  logic [INPUT_BITS_NUM-1:0] weight_in,
    input  logic [INPUT_BITS_NUM-1:0] data_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [INPUT_BITS_NUM-1:0] out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    localparam int W      = INPUT_BITS_NUM;
    localparam int PROD_W = 2 * INPUT_BITS_NUM;
    localparam int CNT_W  = $clog2(VEC_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    mac_state_t                     state_q, state_d;
    logic signed [ACC_BITS_NUM-1:0] acc_q, acc_d;
    logic signed [PROD_W-1:0]       prod_q, prod_d;
    logic                           prod_vld_q, prod_vld_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;

    logic signed [PROD_W-1:0]       w_ext, d_ext;
    logic signed [ACC_BITS_NUM-1:0] bias_acc, prod_acc;
    logic                           accept;
    logic [W-1:0]                   rounded;

    always_comb begin
        w_ext    = {{W{weight_in[W-1]}}, weight_in};
        d_ext    = {{W{data_in[W-1]}}, data_in};
        bias_acc = {{(ACC_BITS_NUM-W){bias_in[W-1]}}, bias_in} <<< FRAC_BITS;
        prod_acc = prod_vld_q ? {{(ACC_BITS_NUM-PROD_W){prod_q[PROD_W-1]}}, prod_q}
                              : '0;
        accept   = (state_q == ST_ACCUM) && in_valid;

        state_d    = state_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        prod_vld_d = 1'b0;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = bias_acc;
                    cnt_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_q + prod_acc;
                if (accept) begin
                    prod_d     = w_ext * d_ext;
                    prod_vld_d = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                acc_d   = acc_q + prod_acc;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    if (start) begin
                        acc_d   = bias_acc;
                        cnt_d   = '0;
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Restart wins over everything in flight, including a term offered this cycle.
        if (start && (state_q == ST_ACCUM || state_q == ST_DRAIN)) begin
            acc_d      = bias_acc;
            cnt_d      = '0;
            prod_vld_d = 1'b0;
            state_d    = ST_ACCUM;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            prod_q     <= prod_d;
            prod_vld_q <= prod_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    fxp_round_sat #(
        .ACC_W (ACC_BITS_NUM),
        .OUT_W (INPUT_BITS_NUM),
        .FRAC  (FRAC_BITS)
    ) u_round_sat (
        .acc_in  (acc_q),
        .res_out (rounded)
    );

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = out_valid ? rounded : '0;

endmodule
